fll_cfg_master: RTL and testbench

Initiator for the FLL configuration port: the side that drives `fll_req/fll_wrn/fll_add/fll_data` and consumes `fll_ack/fll_r_data/fll_lock`. It sits between the SoC control bus (a simple valid/ready command/response channel) and the clock/reset generator's FLL port. It converts one bus command into one four-phase req/ack transaction and returns read data or an error. It also synchronises the FLL lock indication into the bus clock domain.

---
 rtl/fll_cfg_master.sv | 132 +++++++++++++
 tb/tb_fll_cfg_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_master.sv
// Bridges one control-bus command to one four-phase req/ack transaction on the FLL
// configuration port, and synchronises the FLL lock flag. Optional timeout: FLL_CFG_TIMEOUT_EN.
module fll_cfg_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_wr_i,
    input  logic [1:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        lock_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACKLOW = 2'd2,
        RSP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        expired;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [1:0]  lock_sync;

    // Handshakes: a command transfers on a rising edge where cmd_valid_i and cmd_ready_o
    // are both high; a response transfers where rsp_valid_o and rsp_ready_i are both high.
    // Withholding ready while ack is still high absorbs a stale ack left by a timeout.
    assign accept = cmd_valid_i & cmd_ready_o;

`ifdef FLL_CFG_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign expired = ((state == REQ) || (state == ACKLOW)) &&
                     (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= 16'd0;
        end else if (accept) begin
            wait_cnt <= 16'd0;
        end else if ((state == REQ) && fll_ack_i) begin
            wait_cnt <= 16'd0;
        end else if ((state == REQ) || (state == ACKLOW)) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        cmd_ready_o = 1'b0;
        fll_req_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = ~fll_ack_i & ~rst_i;
                if (cmd_valid_i && !fll_ack_i) state_nxt = REQ;
            end
            REQ: begin
                fll_req_o = 1'b1;
                // Ack takes priority over an expiry on the same cycle.
                if (fll_ack_i)    state_nxt = ACKLOW;
                else if (expired) state_nxt = RSP;
            end
            ACKLOW: begin
                if (!fll_ack_i || expired) state_nxt = RSP;
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            fll_wrn_o  <= 1'b0;
            fll_add_o  <= 2'd0;
            fll_data_o <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                fll_wrn_o  <= ~cmd_wr_i;
                fll_add_o  <= cmd_addr_i;
                fll_data_o <= cmd_wdata_i;
                rdata_q    <= 32'd0;
                err_q      <= 1'b0;
            end else if ((state == REQ) && fll_ack_i) begin
                rdata_q <= fll_wrn_o ? fll_r_data_i : 32'd0;
            end else if ((state == REQ || (state == ACKLOW && fll_ack_i)) && expired) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lock_sync <= 2'b00;
        else       lock_sync <= {lock_sync[0], fll_lock_i};
    end

    assign lock_o      = lock_sync[1];
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_fll_cfg_master.sv
// Randomised bench for fll_cfg_master: a register-file FLL responder with selectable ack
// behaviour, an expected-response queue fed by a memory model, and one summary line.
module tb_fll_cfg_master;

`ifdef FLL_CFG_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_addr = 2'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        fll_req;
    logic        fll_wrn;
    logic [1:0]  fll_add;
    logic [31:0] fll_data;
    logic        fll_ack;
    logic [31:0] fll_r_data;
    logic        fll_lock = 1'b0;
    logic        lock;

    int n_checks = 0;
    int n_pass = 0;

    // Responder: mode 0 = ack follows req combinationally, 1 = ack after ack_delay cycles of req,
    // 2 = never acks. late_ack forces ack high in modes 1/2.
    int          resp_mode = 0;
    int          ack_delay = 1;
    logic        late_ack = 1'b0;
    logic        ack_q;
    int          req_cnt;
    logic [31:0] fll_regs [4];

    logic [31:0] model_mem [4];
    logic [32:0] exp_q [$];

    logic        r_wr;
    logic [1:0]  r_addr;
    logic [31:0] r_data;
    int          r_bp;
    int          lat;
    int          reqn;
    int          n;

    fll_cfg_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .fll_req_o(fll_req), .fll_wrn_o(fll_wrn), .fll_add_o(fll_add), .fll_data_o(fll_data),
        .fll_ack_i(fll_ack), .fll_r_data_i(fll_r_data),
        .fll_lock_i(fll_lock), .lock_o(lock)
    );

    always #5 clk = ~clk;

    assign fll_ack    = (resp_mode == 0) ? fll_req : (ack_q | late_ack);
    assign fll_r_data = fll_regs[fll_add];

    always @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            req_cnt     <= 0;
            fll_regs[0] <= 32'h1111_1111;
            fll_regs[1] <= 32'hCAFE_F00D;
            fll_regs[2] <= 32'h2222_2222;
            fll_regs[3] <= 32'h3333_3333;
        end else begin
            if (fll_req && fll_ack && !fll_wrn) fll_regs[fll_add] <= fll_data;
            if (resp_mode == 1 && fll_req) begin
                if (req_cnt == ack_delay - 1) ack_q <= 1'b1;
                req_cnt <= req_cnt + 1;
            end else if (!fll_req) begin
                ack_q   <= 1'b0;
                req_cnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic init_model();
        model_mem[0] = 32'h1111_1111;
        model_mem[1] = 32'hCAFE_F00D;
        model_mem[2] = 32'h2222_2222;
        model_mem[3] = 32'h3333_3333;
    endtask

    // Asserts reset for one edge and checks every reset value on the following negedge.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_req",       32'(fll_req),   32'd0);
        check("rst_wrn",       32'(fll_wrn),   32'd0);
        check("rst_add",       32'(fll_add),   32'd0);
        check("rst_data",      fll_data,       32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata",     rsp_rdata,      32'd0);
        check("rst_err",       32'(rsp_err),   32'd0);
        check("rst_lock",      32'(lock),      32'd0);
        rst = 1'b0;
        init_model();
    endtask

    // Presents one command, checks the first REQ cycle, then waits up to max_wait cycles
    // for a response. lat counts cycles from the accept edge, reqn the cycles req was high.
    task automatic issue_and_wait(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                                  input int max_wait, output int lat_o, output int reqn_o);
        int k;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("req_rise", 32'(fll_req), 32'd1);
        check("req_wrn",  32'(fll_wrn), 32'(!wr));
        check("req_add",  32'(fll_add), 32'(addr));
        check("req_data", fll_data,     wdata);
        lat_o  = 1;
        reqn_o = 1;
        while (!rsp_valid && lat_o < max_wait) begin
            @(negedge clk);
            lat_o++;
            if (fll_req) reqn_o++;
        end
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_txn(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                          input int bp);
        logic [32:0] exp;
        int exp_lat;
        int exp_reqn;
        exp_lat  = (resp_mode == 0) ? 3 : ack_delay + 4;
        exp_reqn = (resp_mode == 0) ? 1 : ack_delay + 1;
        if (wr) begin
            model_mem[addr] = wdata;
            exp_q.push_back({1'b0, 32'd0});
        end else begin
            exp_q.push_back({1'b0, model_mem[addr]});
        end
        issue_and_wait(wr, addr, wdata, 300, lat, reqn);
        exp = exp_q.pop_front();
        check("rsp_valid",  32'(rsp_valid), 32'd1);
        check("latency",    32'(lat),       32'(exp_lat));
        check("req_cycles", 32'(reqn),      32'(exp_reqn));
        check("rdata",      rsp_rdata,      exp[31:0]);
        check("err",        32'(rsp_err),   32'(exp[32]));
        check("hold_data",  fll_data,       wdata);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata,      exp[31:0]);
            check("bp_ready", 32'(cmd_ready), 32'd0);
        end
        consume_rsp();
    endtask

    initial begin
        init_model();
        repeat (2) @(negedge clk);
        apply_reset();
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        resp_mode = 0;
        do_txn(1'b1, 2'd2, 32'h1234_5678, 0);
        do_txn(1'b0, 2'd2, 32'h0, 0);

        resp_mode = 1;
        ack_delay = 5;
        do_txn(1'b0, 2'd1, 32'h0, 0);

        resp_mode = 0;
        do_txn(1'b0, 2'd3, 32'h0, 10);

        for (int t = 0; t < 24; t++) begin
            resp_mode = $urandom_range(0, 1);
            ack_delay = $urandom_range(1, 6);
            r_wr      = 1'($urandom_range(0, 1));
            r_addr    = 2'($urandom_range(0, 3));
            r_data    = $urandom();
            r_bp      = $urandom_range(0, 3);
            do_txn(r_wr, r_addr, r_data, r_bp);
        end

`ifdef FLL_CFG_TIMEOUT_EN
        resp_mode = 2;
        issue_and_wait(1'b0, 2'd3, 32'h0, 300, lat, reqn);
        check("to_valid",  32'(rsp_valid), 32'd1);
        check("to_req",    32'(reqn),      32'(TO));
        check("to_lat",    32'(lat),       32'(TO + 1));
        check("to_err",    32'(rsp_err),   32'd1);
        check("to_rdata",  rsp_rdata,      32'd0);
        check("to_reqlow", 32'(fll_req),   32'd0);
        consume_rsp();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            late_ack = 1'b1;
            #1 check("late_ack_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        late_ack = 1'b0;
        #1 check("after_late_ready", 32'(cmd_ready), 32'd1);
`else
        resp_mode = 2;
        issue_and_wait(1'b0, 2'd3, 32'h0, 1000, lat, reqn);
        check("noto_valid", 32'(rsp_valid), 32'd0);
        check("noto_err",   32'(rsp_err),   32'd0);
        check("noto_req",   32'(fll_req),   32'd1);
        apply_reset();
`endif

        resp_mode = 2;
        issue_and_wait(1'b1, 2'd3, 32'hDEAD_BEEF, 4, lat, reqn);
        check("midreq_req", 32'(fll_req), 32'd1);
        apply_reset();
        resp_mode = 0;
        do_txn(1'b1, 2'd0, 32'h0BAD_F00D, 0);
        do_txn(1'b0, 2'd0, 32'h0, 1);

        @(negedge clk);
        fll_lock = 1'b1;
        n = 0;
        while (!lock && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("lock_rise", 32'(lock), 32'd1);
        check("lock_rise_lat", 32'(n), 32'd2);
        fll_lock = 1'b0;
        n = 0;
        while (lock && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("lock_fall", 32'(lock), 32'd0);
        check("lock_fall_lat", 32'(n), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
